// File: rtl/wb_width_downsizer.sv
// Wishbone classic width down-converter: one wide master access becomes up to
// MDW/SDW narrow slave beats, one per byte-lane group with any select bit set.
module wb_width_downsizer #(
  parameter int AW          = 32,
  parameter int MDW         = 32,
  parameter int SDW         = 16,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [AW-1:0]    wbm_adr_i,
  input  logic [MDW-1:0]   wbm_dat_i,
  input  logic [MDW/8-1:0] wbm_sel_i,
  input  logic             wbm_we_i,
  input  logic             wbm_cyc_i,
  input  logic             wbm_stb_i,
  output logic [MDW-1:0]   wbm_dat_o,
  output logic             wbm_ack_o,
  output logic             wbm_err_o,
  output logic             wbm_rty_o,
  output logic [AW-1:0]    wbs_adr_o,
  output logic [SDW-1:0]   wbs_dat_o,
  output logic [SDW/8-1:0] wbs_sel_o,
  output logic             wbs_we_o,
  output logic             wbs_cyc_o,
  output logic             wbs_stb_o,
  input  logic [SDW-1:0]   wbs_dat_i,
  input  logic             wbs_ack_i,
  input  logic             wbs_err_i,
  input  logic             wbs_rty_i
);

  localparam int RATIO = MDW / SDW;
  localparam int MSB   = MDW / 8;
  localparam int SSB   = SDW / 8;
  localparam int LW    = $clog2(RATIO);
  localparam int LSSB  = $clog2(SSB);
  localparam int TW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {IDLE, BEAT, RESP} state_e;

  function automatic logic [RATIO-1:0] lane_mask(input logic [MSB-1:0] sel);
    logic [RATIO-1:0] m;
    for (int k = 0; k < RATIO; k++) m[k] = |sel[k*SSB +: SSB];
    return m;
  endfunction

  function automatic logic [LW-1:0] first_lane(input logic [RATIO-1:0] m);
    logic [LW-1:0] idx;
    idx = '0;
    for (int k = RATIO - 1; k >= 0; k--) if (m[k]) idx = LW'(k);
    return idx;
  endfunction

  // Word-aligned master address with the lane index placed above the slave byte offset.
  function automatic logic [AW-1:0] beat_adr(input logic [AW-1:0] adr, input logic [LW-1:0] lane);
    return (adr & ~AW'(MSB - 1)) | (AW'(lane) << LSSB);
  endfunction

  state_e           state_q, state_d;
  logic [AW-1:0]    adr_q, adr_d;
  logic             we_q, we_d;
  logic [MDW-1:0]   dat_q, dat_d;
  logic [MSB-1:0]   sel_q, sel_d;
  logic [RATIO-1:0] mask_q, mask_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [MDW-1:0]   rdata_q, rdata_d;
  logic [TW-1:0]    tmo_q, tmo_d;

  logic [MDW-1:0]   wbm_dat_q, wbm_dat_d;
  logic             wbm_ack_q, wbm_ack_d;
  logic             wbm_err_q, wbm_err_d;
  logic             wbm_rty_q, wbm_rty_d;
  logic [AW-1:0]    wbs_adr_q, wbs_adr_d;
  logic [SDW-1:0]   wbs_dat_q, wbs_dat_d;
  logic [SSB-1:0]   wbs_sel_q, wbs_sel_d;
  logic             wbs_we_q, wbs_we_d;
  logic             wbs_cyc_q, wbs_cyc_d;
  logic             wbs_stb_q, wbs_stb_d;

  logic [RATIO-1:0] next_mask;
  logic [LW-1:0]    next_lane;
  logic             drop;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d   = state_q;
    adr_d     = adr_q;
    we_d      = we_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    mask_d    = mask_q;
    lane_d    = lane_q;
    rdata_d   = rdata_q;
    tmo_d     = tmo_q;
    wbm_dat_d = '0;
    wbm_ack_d = 1'b0;
    wbm_err_d = 1'b0;
    wbm_rty_d = 1'b0;
    wbs_adr_d = wbs_adr_q;
    wbs_dat_d = wbs_dat_q;
    wbs_sel_d = wbs_sel_q;
    wbs_we_d  = wbs_we_q;
    wbs_cyc_d = wbs_cyc_q;
    wbs_stb_d = wbs_stb_q;
    drop      = 1'b0;
    next_mask = mask_q & ~(RATIO'(1) << lane_q);
    next_lane = first_lane(next_mask);

    case (state_q)
      IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          adr_d   = wbm_adr_i;
          we_d    = wbm_we_i;
          dat_d   = wbm_dat_i;
          sel_d   = wbm_sel_i;
          mask_d  = lane_mask(wbm_sel_i);
          rdata_d = '0;
          tmo_d   = '0;
          if (mask_d == '0) begin
            state_d   = RESP;
            wbm_ack_d = 1'b1;
          end else begin
            state_d   = BEAT;
            lane_d    = first_lane(mask_d);
            wbs_cyc_d = 1'b1;
            wbs_stb_d = 1'b1;
            wbs_we_d  = wbm_we_i;
            wbs_adr_d = beat_adr(wbm_adr_i, lane_d);
            wbs_sel_d = wbm_sel_i[lane_d*SSB +: SSB];
            wbs_dat_d = wbm_dat_i[lane_d*SDW +: SDW];
          end
        end
      end
      BEAT: begin
        tmo_d = tmo_q + TW'(1);
        if (!wbm_cyc_i) begin
          // Master abort wins over any response arriving in the same cycle.
          state_d = IDLE;
          drop    = 1'b1;
        end else if (wbs_err_i) begin
          state_d   = RESP;
          wbm_err_d = 1'b1;
          drop      = 1'b1;
        end else if (wbs_rty_i) begin
          state_d   = RESP;
          wbm_rty_d = 1'b1;
          drop      = 1'b1;
        end else if (wbs_ack_i) begin
          if (!we_q) rdata_d[lane_q*SDW +: SDW] = wbs_dat_i;
          if (next_mask != '0) begin
            mask_d    = next_mask;
            lane_d    = next_lane;
            tmo_d     = '0;
            wbs_adr_d = beat_adr(adr_q, next_lane);
            wbs_sel_d = sel_q[next_lane*SSB +: SSB];
            wbs_dat_d = dat_q[next_lane*SDW +: SDW];
          end else begin
            state_d   = RESP;
            wbm_ack_d = 1'b1;
            wbm_dat_d = rdata_d;
            drop      = 1'b1;
          end
        end else if (TIMEOUT_CYC > 0 && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d   = RESP;
          wbm_err_d = 1'b1;
          drop      = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (drop) begin
      wbs_cyc_d = 1'b0;
      wbs_stb_d = 1'b0;
      wbs_we_d  = 1'b0;
      wbs_adr_d = '0;
      wbs_dat_d = '0;
      wbs_sel_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      adr_q     <= '0;
      we_q      <= 1'b0;
      dat_q     <= '0;
      sel_q     <= '0;
      mask_q    <= '0;
      lane_q    <= '0;
      rdata_q   <= '0;
      tmo_q     <= '0;
      wbm_dat_q <= '0;
      wbm_ack_q <= 1'b0;
      wbm_err_q <= 1'b0;
      wbm_rty_q <= 1'b0;
      wbs_adr_q <= '0;
      wbs_dat_q <= '0;
      wbs_sel_q <= '0;
      wbs_we_q  <= 1'b0;
      wbs_cyc_q <= 1'b0;
      wbs_stb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      we_q      <= we_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      mask_q    <= mask_d;
      lane_q    <= lane_d;
      rdata_q   <= rdata_d;
      tmo_q     <= tmo_d;
      wbm_dat_q <= wbm_dat_d;
      wbm_ack_q <= wbm_ack_d;
      wbm_err_q <= wbm_err_d;
      wbm_rty_q <= wbm_rty_d;
      wbs_adr_q <= wbs_adr_d;
      wbs_dat_q <= wbs_dat_d;
      wbs_sel_q <= wbs_sel_d;
      wbs_we_q  <= wbs_we_d;
      wbs_cyc_q <= wbs_cyc_d;
      wbs_stb_q <= wbs_stb_d;
    end
  end

  assign wbm_dat_o = wbm_dat_q;
  assign wbm_ack_o = wbm_ack_q;
  assign wbm_err_o = wbm_err_q;
  assign wbm_rty_o = wbm_rty_q;
  assign wbs_adr_o = wbs_adr_q;
  assign wbs_dat_o = wbs_dat_q;
  assign wbs_sel_o = wbs_sel_q;
  assign wbs_we_o  = wbs_we_q;
  assign wbs_cyc_o = wbs_cyc_q;
  assign wbs_stb_o = wbs_stb_q;

endmodule

// File: tb/tb_wb_width_downsizer.sv
// Bench for wb_width_downsizer: a 32->16 instance with an 8-cycle timeout and a
// 32->8 instance without, driven from one directed sequence with a scoreboard.
module tb_wb_width_downsizer;

  localparam logic [2:0] K_NONE = 3'b000;
  localparam logic [2:0] K_ACK  = 3'b100;
  localparam logic [2:0] K_ERR  = 3'b010;
  localparam logic [2:0] K_RTY  = 3'b001;
  localparam int         BOUND  = 40;

  typedef enum int {R_ACK, R_ERR, R_RTY, R_NONE} reply_e;
  typedef struct {logic [31:0] adr; logic [1:0] sel; logic [15:0] dat; logic we;} beat_t;
  typedef struct {reply_e kind; logic [15:0] rdat;} reply_t;
  typedef struct {logic [2:0] kind; logic [31:0] dat; int cyc;} mresp_t;

  beat_t  exp_beats[$];
  reply_t replies[$];
  mresp_t exp_resp[$];

  int checks = 0;
  int errors = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        use8;
  logic [31:0] m_adr, m_dat;
  logic [3:0]  m_sel;
  logic        m_we, m_cyc, m_stb;
  logic [15:0] s_rdat;
  logic        s_ack, s_err, s_rty;

  logic [31:0] a_mdat, a_sadr;
  logic        a_ack, a_err, a_rty, a_swe, a_scyc, a_sstb;
  logic [15:0] a_sdat;
  logic [1:0]  a_ssel;
  logic [31:0] b_mdat, b_sadr;
  logic        b_ack, b_err, b_rty, b_swe, b_scyc, b_sstb;
  logic [7:0]  b_sdat;
  logic [0:0]  b_ssel;

  logic [31:0] o_mdat, o_sadr;
  logic [2:0]  o_resp;
  logic [15:0] o_sdat;
  logic [1:0]  o_ssel;
  logic        o_swe, o_scyc, o_sstb;

  always #5 clk = ~clk;

  wb_width_downsizer #(.AW(32), .MDW(32), .SDW(16), .TIMEOUT_CYC(8)) dut16 (
    .clk_i(clk), .rst_i(rst),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
    .wbm_cyc_i(m_cyc & ~use8), .wbm_stb_i(m_stb & ~use8),
    .wbm_dat_o(a_mdat), .wbm_ack_o(a_ack), .wbm_err_o(a_err), .wbm_rty_o(a_rty),
    .wbs_adr_o(a_sadr), .wbs_dat_o(a_sdat), .wbs_sel_o(a_ssel), .wbs_we_o(a_swe),
    .wbs_cyc_o(a_scyc), .wbs_stb_o(a_sstb),
    .wbs_dat_i(s_rdat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty)
  );

  wb_width_downsizer #(.AW(32), .MDW(32), .SDW(8), .TIMEOUT_CYC(0)) dut8 (
    .clk_i(clk), .rst_i(rst),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
    .wbm_cyc_i(m_cyc & use8), .wbm_stb_i(m_stb & use8),
    .wbm_dat_o(b_mdat), .wbm_ack_o(b_ack), .wbm_err_o(b_err), .wbm_rty_o(b_rty),
    .wbs_adr_o(b_sadr), .wbs_dat_o(b_sdat), .wbs_sel_o(b_ssel), .wbs_we_o(b_swe),
    .wbs_cyc_o(b_scyc), .wbs_stb_o(b_sstb),
    .wbs_dat_i(s_rdat[7:0]), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty)
  );

  assign o_mdat = use8 ? b_mdat : a_mdat;
  assign o_resp = use8 ? {b_ack, b_err, b_rty} : {a_ack, a_err, a_rty};
  assign o_sadr = use8 ? b_sadr : a_sadr;
  assign o_sdat = use8 ? {8'h00, b_sdat} : a_sdat;
  assign o_ssel = use8 ? {1'b0, b_ssel} : a_ssel;
  assign o_swe  = use8 ? b_swe : a_swe;
  assign o_scyc = use8 ? b_scyc : a_scyc;
  assign o_sstb = use8 ? b_sstb : a_sstb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input logic [31:0] adr, input logic [1:0] sel, input logic [15:0] dat, input logic we);
    beat_t b;
    b.adr = adr; b.sel = sel; b.dat = dat; b.we = we;
    exp_beats.push_back(b);
  endtask

  task automatic push_reply(input reply_e kind, input logic [15:0] rdat);
    reply_t r;
    r.kind = kind; r.rdat = rdat;
    replies.push_back(r);
  endtask

  task automatic push_resp(input logic [2:0] kind, input logic [31:0] dat, input int cyc);
    mresp_t e;
    e.kind = kind; e.dat = dat; e.cyc = cyc;
    exp_resp.push_back(e);
  endtask

  // Presents one master request and acts as the slave, one decision per cycle at negedge.
  task automatic access(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel, input logic we);
    int     cyc;
    bit     done;
    bit     in_beat;
    beat_t  b;
    reply_t r;
    mresp_t e;
    m_adr = adr; m_dat = dat; m_sel = sel; m_we = we; m_cyc = 1'b1; m_stb = 1'b1;
    cyc = 0; done = 1'b0; in_beat = 1'b0;
    while (!done && cyc < BOUND) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_rdat = '0;
      if (o_resp != K_NONE) begin
        check("resp_expected", 32'(exp_resp.size() > 0), 1);
        if (exp_resp.size() > 0) begin
          e = exp_resp.pop_front();
          check("resp_kind", 32'(o_resp), 32'(e.kind));
          check("resp_data", o_mdat, e.dat);
          check("resp_cycle", cyc, e.cyc);
        end
        check("scyc_at_resp", 32'({o_scyc, o_sstb}), 0);
        m_cyc = 1'b0; m_stb = 1'b0;
        done = 1'b1;
      end else if (o_sstb && !in_beat) begin
        check("beat_expected", 32'(exp_beats.size() > 0), 1);
        if (exp_beats.size() > 0) begin
          b = exp_beats.pop_front();
          check("beat_adr", o_sadr, b.adr);
          check("beat_sel", 32'(o_ssel), 32'(b.sel));
          check("beat_dat", 32'(o_sdat), 32'(b.dat));
          check("beat_we_cyc", 32'({o_swe, o_scyc}), 32'({b.we, 1'b1}));
        end
        if (replies.size() > 0) begin
          r = replies.pop_front();
          case (r.kind)
            R_ACK: begin s_ack = 1'b1; s_rdat = r.rdat; end
            R_ERR: begin s_err = 1'b1; s_rty = 1'b1; s_ack = 1'b1; end
            R_RTY: begin s_rty = 1'b1; s_ack = 1'b1; end
            default: ;
          endcase
          in_beat = (r.kind == R_NONE);
        end
      end
    end
    check("resp_within_bound", 32'(done), 1);
    m_cyc = 1'b0; m_stb = 1'b0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_rdat = '0;
    @(posedge clk);
    @(negedge clk);
    check("idle_resp", 32'(o_resp), 0);
    check("idle_mdat", o_mdat, 0);
    check("idle_scyc", 32'({o_scyc, o_sstb}), 0);
    check("leftover_beats", exp_beats.size(), 0);
    check("leftover_replies", replies.size(), 0);
    exp_beats.delete();
    replies.delete();
    exp_resp.delete();
  endtask

  initial begin
    rst = 1'b1; use8 = 1'b0;
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
    s_rdat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_resp", 32'(o_resp), 0);
    check("rst_mdat", o_mdat, 0);
    check("rst_sadr", o_sadr, 0);
    check("rst_sctl", 32'({o_ssel, o_sdat, o_swe, o_scyc, o_sstb}), 0);
    rst = 1'b0;
    @(negedge clk);

    // Full-width zero-wait read, two beats.
    push_beat(32'h100, 2'h3, 16'h0, 1'b0);
    push_beat(32'h102, 2'h3, 16'h0, 1'b0);
    push_reply(R_ACK, 16'hBEEF);
    push_reply(R_ACK, 16'hDEAD);
    push_resp(K_ACK, 32'hDEADBEEF, 3);
    access(32'h100, 32'h0, 4'hF, 1'b0);

    // Upper-half write only: lane 0 skipped.
    push_beat(32'h202, 2'h3, 16'h1234, 1'b1);
    push_reply(R_ACK, 16'h0);
    push_resp(K_ACK, 32'h0, 2);
    access(32'h200, 32'h12345678, 4'hC, 1'b1);

    // 8-bit slave, sparse select: bytes 1 and 3 skipped.
    use8 = 1'b1;
    push_beat(32'h300, 2'h1, 16'h0, 1'b0);
    push_beat(32'h302, 2'h1, 16'h0, 1'b0);
    push_reply(R_ACK, 16'h00AA);
    push_reply(R_ACK, 16'h00CC);
    push_resp(K_ACK, 32'h00CC00AA, 3);
    access(32'h300, 32'h0, 4'h5, 1'b0);

    // Error on second of four beats ends the access (err also carries rty and ack).
    push_beat(32'h400, 2'h1, 16'h0, 1'b0);
    push_beat(32'h401, 2'h1, 16'h0, 1'b0);
    push_reply(R_ACK, 16'h0011);
    push_reply(R_ERR, 16'h0);
    push_resp(K_ERR, 32'h0, 3);
    access(32'h400, 32'h0, 4'hF, 1'b0);
    use8 = 1'b0;

    // Retry on the second beat (rty also carries ack).
    push_beat(32'h500, 2'h3, 16'h0, 1'b0);
    push_beat(32'h502, 2'h3, 16'h0, 1'b0);
    push_reply(R_ACK, 16'h2222);
    push_reply(R_RTY, 16'h0);
    push_resp(K_RTY, 32'h0, 3);
    access(32'h500, 32'h0, 4'hF, 1'b0);

    // Silent slave: strobe held 8 cycles, err on cycle 9.
    push_beat(32'h600, 2'h3, 16'h0, 1'b0);
    push_reply(R_NONE, 16'h0);
    push_resp(K_ERR, 32'h0, 9);
    access(32'h600, 32'h0, 4'h3, 1'b0);

    // Empty select: immediate ack, no slave cycle.
    push_resp(K_ACK, 32'h0, 1);
    access(32'h700, 32'hFFFFFFFF, 4'h0, 1'b0);

    // Master abort in beat 1, with a late slave ack in the same cycle.
    m_adr = 32'h800; m_dat = '0; m_sel = 4'hF; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_beat_adr", o_sadr, 32'h800);
    check("abort_beat_stb", 32'(o_sstb), 1);
    m_cyc = 1'b0; m_stb = 1'b0; s_ack = 1'b1; s_rdat = 16'h5555;
    @(posedge clk);
    @(negedge clk);
    s_ack = 1'b0; s_rdat = '0;
    check("abort_scyc", 32'({o_scyc, o_sstb}), 0);
    check("abort_noresp", 32'(o_resp), 0);
    repeat (2) @(negedge clk);
    check("abort_noresp_later", 32'({o_resp, o_scyc}), 0);

    // Reset asserted mid-beat clears outputs without a clock edge.
    m_adr = 32'h900; m_sel = 4'hF; m_cyc = 1'b1; m_stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("prerst_stb", 32'({o_scyc, o_sstb}), 32'h3);
    rst = 1'b1; m_cyc = 1'b0; m_stb = 1'b0;
    #1;
    check("midrst_sctl", 32'({o_ssel, o_sdat, o_swe, o_scyc, o_sstb}), 0);
    check("midrst_sadr", o_sadr, 0);
    check("midrst_resp", 32'(o_resp), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Normal read after reset.
    push_beat(32'hA00, 2'h3, 16'h0, 1'b0);
    push_beat(32'hA02, 2'h3, 16'h0, 1'b0);
    push_reply(R_ACK, 16'h5678);
    push_reply(R_ACK, 16'h9ABC);
    push_resp(K_ACK, 32'h9ABC5678, 3);
    access(32'hA00, 32'h0, 4'hF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_width_downsizer.md
Name: wb_width_downsizer

Overview:
- Parametrised Wishbone classic-cycle width down-converter between one wide master port and one narrow slave port.
- A single master access is split into up to RATIO sequential narrow slave beats, one per byte-lane group that has any select bit set.
- Read data is assembled from the beats, and the master sees one ack, err or rty for the whole access.
- Sits between the 32-bit CPU/DMA fabric and 16-bit or 8-bit peripherals/memory; generalises fixed half-word steering to multi-beat splitting with a bus timeout.

Parameters:
- AW, 32, address width (byte address) on both ports.
- MDW, 32, master data width in bits; power of two, multiple of 8.
- SDW, 16, slave data width in bits; power of two, 8 ≤ SDW < MDW.
- TIMEOUT_CYC, 0, maximum cycles a slave beat may wait for a response; 0 disables the timeout.
- Derived: RATIO = MDW/SDW (2, 4 or 8); MSB = MDW/8; SSB = SDW/8.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- wbm_adr_i  in  AW  master byte address.
- wbm_dat_i  in  MDW  master write data.
- wbm_sel_i  in  MSB  master byte selects.
- wbm_we_i  in  1  master write enable.
- wbm_cyc_i  in  1  master cycle.
- wbm_stb_i  in  1  master strobe.
- wbm_dat_o  out  MDW  assembled read data.
- wbm_ack_o  out  1  access done.
- wbm_err_o  out  1  access error (slave err or timeout).
- wbm_rty_o  out  1  access retry.
- wbs_adr_o  out  AW  slave byte address.
- wbs_dat_o  out  SDW  slave write data.
- wbs_sel_o  out  SSB  slave byte selects.
- wbs_we_o  out  1  slave write enable.
- wbs_cyc_o  out  1  slave cycle.
- wbs_stb_o  out  1  slave strobe.
- wbs_dat_i  in  SDW  slave read data.
- wbs_ack_i  in  1  slave ack.
- wbs_err_i  in  1  slave err.
- wbs_rty_i  in  1  slave retry.

Behaviour:
- One clock domain, clk_i. Reset is asynchronous and active-high on rst_i.
- All outputs are registered. In reset every output is 0 and the FSM is in IDLE.
- FSM states: IDLE, BEAT, RESP.
- IDLE:
  - On wbm_cyc_i & wbm_stb_i, latch adr, we, dat and sel.
  - Compute lane mask: lane k is active iff sel[k*SSB +: SSB] != 0.
  - Clear the read assembly register to 0.
  - If the mask is 0: go to RESP with ack. No slave cycle is issued.
  - Otherwise: select the lowest active lane and go to BEAT.
- BEAT:
  - wbs_cyc_o = wbs_stb_o = 1; wbs_we_o = latched we.
  - wbs_adr_o = {adr[AW-1:log2 MSB], k, log2 SSB zero bits}, where k is the lane index.
  - wbs_sel_o and wbs_dat_o = lane k slices of the latched sel and dat.
  - Slave outputs are stable for the whole beat.
- Response priority in BEAT: err > rty > ack.
  - err: go to RESP with err.
  - rty: go to RESP with rty.
  - ack: store wbs_dat_i into assembly slice k (reads only). If a higher active lane remains, advance to it and stay in BEAT; wbs_stb_o stays high, new address is presented the next cycle. Otherwise go to RESP with ack.
  - Inactive lanes are skipped with no idle cycle.
  - On ack, err or rty, wbs_cyc_o and wbs_stb_o drop in the same registered update unless another beat follows.
- Timeout (TIMEOUT_CYC > 0 only):
  - Counter is reset at the start of each beat.
  - If TIMEOUT_CYC cycles elapse in one beat without a response, drop wbs_cyc_o/wbs_stb_o and go to RESP with err.
- RESP:
  - Exactly one of wbm_ack_o / wbm_err_o / wbm_rty_o is high for exactly one cycle.
  - wbm_dat_o = assembly register. Unselected lanes read as 0. Value is 0 on err, rty and writes.
  - Return to IDLE. wbm_dat_o returns to 0 with the strobe.
- Latency: master request at cycle 0 → first slave stb at cycle 1.
  - Each beat takes ≥ 1 cycle plus slave wait states.
  - Master response arrives 1 cycle after the final slave response.
  - A full-width access to a zero-wait slave with RATIO=2 acks at cycle 3.
- Master abort: if wbm_cyc_i falls in BEAT, drop wbs_cyc_o/wbs_stb_o next cycle, go to IDLE, and issue no master response. A late slave ack is ignored.
- No new request is accepted in RESP. The master must drop stb on its response cycle; a request seen in IDLE after RESP is a new access.
- Reset asserted mid-access: all outputs go to 0 immediately (asynchronous), FSM to IDLE, latched state discarded.

Test Plan:
- MDW=32, SDW=16, zero-wait read, adr=0x100, sel=0xF; slave returns 0xBEEF then 0xDEAD → two beats at slave adr 0x100 then 0x102 with sel=0x3; master ack at cycle 3 with dat=0xDEADBEEF.
- Write adr=0x200, sel=0xC, dat=0x12345678 → one beat at adr 0x202, sel=0x3, dat=0x1234, we=1; no beat at 0x200; master ack.
- MDW=32, SDW=8, read sel=0x5, slave returns 0xAA at 0x300 and 0xCC at 0x302 → beats at 0x300 and 0x302 only (bytes 1 and 3 skipped); master dat=0x00CC00AA.
- Full read where the second beat gets wbs_err_i → one cycle of wbm_err_o, wbm_dat_o=0, no further beats. Repeat with rty → wbm_rty_o.
- TIMEOUT_CYC=8, slave never responds → wbs_stb_o drops after 8 cycles, wbm_err_o pulses once. Also sel=0x0 → ack 1 cycle after request, no slave cyc.
- wbm_cyc_i dropped during beat 1, then rst_i asserted mid-beat on a second access → no master response, slave cyc low next cycle; outputs 0 immediately on reset; a subsequent read completes normally.
